pipeline_hazard_ctrl: RTL and testbench

//  Hazard/stall scheduler for the 5-stage RV32I pipeline (IF-ID-EX-MEM-WB).

---
 rtl/pipeline_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and stall scheduler for a 5-stage RV32I pipeline (IF-ID-EX-MEM-WB).
//
// Operation
//   A 3-entry scoreboard (EX, MEM, WB) records the destination register of
//   every instruction in flight. It is used to detect read-after-write hazards
//   for the instruction currently in ID.
//   A taken branch or jump in EX flushes IF/ID and ID/EX.
//   A hazard freezes PC and IF/ID and sends a bubble into ID/EX.
//   The stall length is not counted by a timer. It ends by itself once the
//   producing instruction has moved far enough down the scoreboard.
//
// Parameters
//   WB_BYPASS  1: the register file is write-first, so a match in WB is not a
//                 hazard.
//              0: a match in WB also stalls.
//   CNT_W      Width of the saturating stall and flush performance counters.
//
// Configuration macro
//   FORWARD_EN  When defined, EX/MEM->EX forwarding exists. The only hazard
//               left is load-use: a load in EX whose rd matches a source
//               register of the instruction in ID.
//               When undefined, EX and MEM matches stall, and WB matches also
//               stall if WB_BYPASS is 0.
//
// Ports
//   clk_HZD, rst_HZD          Clock; asynchronous active-high reset.
//   rs1_addr_HZD/rs2_addr_HZD Source registers of the instruction in ID.
//   rs1_used_HZD/rs2_used_HZD The instruction in ID actually reads rs1 / rs2.
//   rd_addr_HZD, RegWrite_HZD Destination register of the instruction in ID,
//                             and whether it is written.
//   MemRead_HZD               The instruction in ID is a load.
//   taken_EX_HZD              The branch/jump in EX redirects the PC in this
//                             cycle.
//   en_PC_HZD, en_IFID_HZD    Register enables for PC and IF/ID.
//   NOP_IFID_HZD/NOP_IDEX_HZD Bubble insertion into IF/ID and ID/EX.
//   state_HZD                 Registered decision of the previous cycle:
//                             00 RUN, 01 STALL, 10 FLUSH.
//   stall_cnt_HZD             Number of stalled cycles (saturating).
//   flush_cnt_HZD             Number of flush events (saturating).
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk_HZD,
    input  logic             rst_HZD,
    input  logic [4:0]       rs1_addr_HZD,
    input  logic [4:0]       rs2_addr_HZD,
    input  logic             rs1_used_HZD,
    input  logic             rs2_used_HZD,
    input  logic [4:0]       rd_addr_HZD,
    input  logic             RegWrite_HZD,
    input  logic             MemRead_HZD,
    input  logic             taken_EX_HZD,
    output logic             en_PC_HZD,
    output logic             en_IFID_HZD,
    output logic             NOP_IFID_HZD,
    output logic             NOP_IDEX_HZD,
    output logic [1:0]       state_HZD,
    output logic [CNT_W-1:0] stall_cnt_HZD,
    output logic [CNT_W-1:0] flush_cnt_HZD
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } sb_entry_t;

    // Scoreboard slots: index 0 = EX, 1 = MEM, 2 = WB.
    sb_entry_t [2:0]  sb_reg;
    sb_entry_t        id_entry;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic [2:0]       hit_rs1, hit_rs2;
    logic             hazard;

    // Writes to x0 never create a dependency, so they enter the scoreboard
    // as invalid entries.
    assign id_entry.v  = RegWrite_HZD && (rd_addr_HZD != 5'd0);
    assign id_entry.rd = rd_addr_HZD;
    assign id_entry.ld = MemRead_HZD;

    // Per-stage match logic.
    // STAGE_CHK removes at elaboration time the stages that can never cause
    // a hazard in this configuration.
    // NEED_LD limits a match to load producers.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_match
`ifdef FORWARD_EN
            localparam bit STAGE_CHK = (gi == 0);
            localparam bit NEED_LD   = 1'b1;
`else
            localparam bit STAGE_CHK = (gi < 2) || (WB_BYPASS == 0);
            localparam bit NEED_LD   = 1'b0;
`endif
            assign hit_rs1[gi] = STAGE_CHK && sb_reg[gi].v
                                 && (sb_reg[gi].rd == rs1_addr_HZD)
                                 && (!NEED_LD || sb_reg[gi].ld);
            assign hit_rs2[gi] = STAGE_CHK && sb_reg[gi].v
                                 && (sb_reg[gi].rd == rs2_addr_HZD)
                                 && (!NEED_LD || sb_reg[gi].ld);
        end
    endgenerate

    assign hazard = (rs1_used_HZD && (rs1_addr_HZD != 5'd0) && (|hit_rs1))
                 || (rs2_used_HZD && (rs2_addr_HZD != 5'd0) && (|hit_rs2));

    // Next-state and output decision.
    // Reset forces the run values, so taken_EX_HZD has no effect during reset.
    always_comb begin
        state_next   = ST_RUN;
        en_PC_HZD    = 1'b1;
        en_IFID_HZD  = 1'b1;
        NOP_IFID_HZD = 1'b0;
        NOP_IDEX_HZD = 1'b0;
        if (rst_HZD) begin
            state_next = ST_RUN;
        end else if (taken_EX_HZD) begin
            // A flush has priority over a stall: the dependent instruction is
            // on the wrong path anyway.
            state_next   = ST_FLUSH;
            NOP_IFID_HZD = 1'b1;
            NOP_IDEX_HZD = 1'b1;
        end else if (hazard) begin
            state_next   = ST_STALL;
            en_PC_HZD    = 1'b0;
            en_IFID_HZD  = 1'b0;
            NOP_IDEX_HZD = 1'b1;
        end
    end

    always_ff @(posedge clk_HZD or posedge rst_HZD) begin
        if (rst_HZD) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // The scoreboard advances every cycle. The bubble that goes into ID/EX
    // on a stall or a flush also goes into the EX slot, so the stalled
    // producer keeps draining.
    always_ff @(posedge clk_HZD or posedge rst_HZD) begin
        if (rst_HZD) begin
            sb_reg <= '0;
        end else begin
            sb_reg[2] <= sb_reg[1];
            sb_reg[1] <= sb_reg[0];
            if (taken_EX_HZD || hazard) begin
                sb_reg[0] <= '0;
            end else begin
                sb_reg[0] <= id_entry;
            end
        end
    end

    always_ff @(posedge clk_HZD or posedge rst_HZD) begin
        if (rst_HZD) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (hazard && !taken_EX_HZD && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (taken_EX_HZD && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign state_HZD     = state_reg;
    assign stall_cnt_HZD = stall_cnt_reg;
    assign flush_cnt_HZD = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl.
// The reference model keeps a history of the instructions issued into EX,
// newest first, with one entry per cycle. A producer at distance d is d
// cycles ahead of the instruction in ID. The expected hazards, outputs,
// state and counters are derived from that history.
// The bench runs a set of directed scenarios, followed by a randomized run
// that includes random resets.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

    localparam int WB_BYPASS = 1;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [4:0]       rs1, rs2, rd;
    logic             u1, u2, rw, mr, tk;
    logic             en_pc, en_ifid, nop_ifid, nop_idex;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(
        .WB_BYPASS(WB_BYPASS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_HZD      (clk),
        .rst_HZD      (rst),
        .rs1_addr_HZD (rs1),
        .rs2_addr_HZD (rs2),
        .rs1_used_HZD (u1),
        .rs2_used_HZD (u2),
        .rd_addr_HZD  (rd),
        .RegWrite_HZD (rw),
        .MemRead_HZD  (mr),
        .taken_EX_HZD (tk),
        .en_PC_HZD    (en_pc),
        .en_IFID_HZD  (en_ifid),
        .NOP_IFID_HZD (nop_ifid),
        .NOP_IDEX_HZD (nop_idex),
        .state_HZD    (state),
        .stall_cnt_HZD(stall_cnt),
        .flush_cnt_HZD(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       ld;
    } ent_t;

    ent_t hist[$];   // hist[0] = issued last cycle (distance 1)
    int   m_state, m_stall, m_flush;

    function automatic void model_reset();
        ent_t b;
        b = '{v: 1'b0, rd: 5'd0, ld: 1'b0};
        hist.delete();
        repeat (3) hist.push_back(b);
        m_state = 0;
        m_stall = 0;
        m_flush = 0;
    endfunction

    function automatic bit depends(input bit [4:0] r);
        for (int d = 1; d <= hist.size(); d++) begin
            ent_t e;
            e = hist[d-1];
            if (e.v && e.rd == r) begin
`ifdef FORWARD_EN
                if (d == 1 && e.ld) return 1'b1;
`else
                if (d <= 2 || (d == 3 && WB_BYPASS == 0)) return 1'b1;
`endif
            end
        end
        return 1'b0;
    endfunction

    // Observations from the last step.
    logic             obs_stall;
    logic [1:0]       obs_state;
    logic [CNT_W-1:0] obs_stall_cnt, obs_flush_cnt;

    // One cycle: drive the inputs at negedge, check 1 ns later, and advance
    // the model at posedge.
    task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic su1, input logic su2, input logic [4:0] d,
                        input logic w, input logic m, input logic t);
        bit hz;
        bit e_pc, e_ifid, e_nifid, e_nidex;
        ent_t ne;
        @(negedge clk);
        rst = r; rs1 = a1; rs2 = a2; u1 = su1; u2 = su2;
        rd = d;  rw = w;   mr = m;   tk = t;
        #1;
        cyc++;
        if (r) model_reset();
        hz = (su1 && a1 != 5'd0 && depends(a1)) || (su2 && a2 != 5'd0 && depends(a2));
        if (r)       {e_pc, e_ifid, e_nifid, e_nidex} = 4'b1100;
        else if (t)  {e_pc, e_ifid, e_nifid, e_nidex} = 4'b1111;
        else if (hz) {e_pc, e_ifid, e_nifid, e_nidex} = 4'b0001;
        else         {e_pc, e_ifid, e_nifid, e_nidex} = 4'b1100;
        check("en_PC",     32'(en_pc),     32'(e_pc));
        check("en_IFID",   32'(en_ifid),   32'(e_ifid));
        check("NOP_IFID",  32'(nop_ifid),  32'(e_nifid));
        check("NOP_IDEX",  32'(nop_idex),  32'(e_nidex));
        check("state",     32'(state),     32'(m_state));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        $display("[TB] cyc=%0d rst=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d w=%0b ld=%0b tk=%0b -> pc=%0b ifid=%0b nifid=%0b nidex=%0b st=%0d sc=%0d fc=%0d",
                 cyc, r, a1, su1, a2, su2, d, w, m, t, en_pc, en_ifid, nop_ifid, nop_idex,
                 state, stall_cnt, flush_cnt);
        obs_stall     = !en_pc;
        obs_state     = state;
        obs_stall_cnt = stall_cnt;
        obs_flush_cnt = flush_cnt;
        @(posedge clk);
        if (!r) begin
            if (t) begin
                m_state = 2;
                if (m_flush < CNT_MAX) m_flush++;
            end else if (hz) begin
                m_state = 1;
                if (m_stall < CNT_MAX) m_stall++;
            end else begin
                m_state = 0;
            end
            if (t || hz) ne = '{v: 1'b0, rd: 5'd0, ld: 1'b0};
            else         ne = '{v: (w && d != 5'd0), rd: d, ld: m};
            hist.push_front(ne);
            hist.pop_back();
        end
    endtask

    // Holds one instruction in ID until it is accepted, and returns the
    // number of stall cycles the DUT imposed on it.
    task automatic issue(input logic [4:0] a1, input logic [4:0] a2, input logic su1,
                         input logic su2, input logic [4:0] d, input logic w,
                         input logic m, output int stalls);
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, a1, a2, su1, su2, d, w, m, 1'b0);
            if (obs_stall) stalls++;
            else break;
        end
    endtask

    task automatic do_reset();
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nop_cycle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef FORWARD_EN
    localparam int EXP_LU = 1, EXP_D1 = 0, EXP_D2 = 0;
`else
    localparam int EXP_LU = 2, EXP_D1 = 2, EXP_D2 = 1;
`endif

    initial begin
        int s;
        int fc0;
        rst = 1'b1; rs1 = '0; rs2 = '0; u1 = 0; u2 = 0; rd = '0; rw = 0; mr = 0; tk = 0;
        model_reset();
        do_reset();

        // 1: load-use, lw x5 ; add x6,x5,x1
        issue(5'd0, 5'd0, 1, 0, 5'd5, 1, 1, s);
        issue(5'd5, 5'd1, 1, 1, 5'd6, 1, 0, s);
        check("loaduse_stalls", 32'(s), 32'(EXP_LU));
        nop_cycle();
        check("loaduse_cnt", 32'(obs_stall_cnt), 32'(EXP_LU));

        // 2: ALU dependency at distances 1, 2 and 3
        do_reset();
        issue(5'd1, 5'd2, 1, 1, 5'd5, 1, 0, s);
        issue(5'd5, 5'd2, 1, 1, 5'd7, 1, 0, s);
        check("dist1_stalls", 32'(s), 32'(EXP_D1));
        issue(5'd1, 5'd2, 1, 1, 5'd5, 1, 0, s);
        nop_cycle();
        issue(5'd5, 5'd2, 1, 1, 5'd7, 1, 0, s);
        check("dist2_stalls", 32'(s), 32'(EXP_D2));
        issue(5'd1, 5'd2, 1, 1, 5'd5, 1, 0, s);
        nop_cycle();
        nop_cycle();
        issue(5'd5, 5'd2, 1, 1, 5'd7, 1, 0, s);
        check("dist3_stalls", 32'(s), 32'(0));

        // 3: x0 destination, and rs2 not used
        issue(5'd1, 5'd2, 1, 1, 5'd0, 1, 1, s);
        issue(5'd0, 5'd0, 1, 1, 5'd1, 1, 0, s);
        check("x0_stalls", 32'(s), 32'(0));
        issue(5'd1, 5'd2, 1, 1, 5'd5, 1, 1, s);
        issue(5'd1, 5'd5, 1, 0, 5'd6, 1, 0, s);
        check("unused_stalls", 32'(s), 32'(0));

        // 4: flush
        do_reset();
        step(1'b0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1'b1);
        nop_cycle();
        check("flush_state", 32'(obs_state), 32'(2));
        check("flush_count", 32'(obs_flush_cnt), 32'(1));

        // 5: flush and stall in the same cycle
        issue(5'd1, 5'd2, 1, 1, 5'd5, 1, 1, s);
        fc0 = 32'(obs_stall_cnt);
        step(1'b0, 5'd5, 5'd2, 1, 1, 5'd7, 1, 0, 1'b1);
        check("flush_over_stall", 32'(obs_stall), 32'(0));
        nop_cycle();
        check("flush_no_stallcnt", 32'(obs_stall_cnt), 32'(fc0));

        // 6: reset in the middle of a stall
        do_reset();
        issue(5'd1, 5'd2, 1, 1, 5'd5, 1, 0, s);
        step(1'b0, 5'd5, 5'd2, 1, 1, 5'd7, 1, 0, 1'b0);
        step(1'b1, 5'd5, 5'd2, 1, 1, 5'd7, 1, 0, 1'b1);
        check("rst_midstall_pc", 32'(obs_stall), 32'(0));
        step(1'b0, 5'd5, 5'd2, 1, 1, 5'd7, 1, 0, 1'b0);
        check("post_rst_nostall", 32'(obs_stall), 32'(0));

        // 7: the stall counter saturates
        do_reset();
        for (int k = 0; k < 20; k++) begin
            issue(5'd0, 5'd0, 1, 0, 5'd5, 1, 1, s);
            issue(5'd5, 5'd1, 1, 1, 5'd6, 1, 0, s);
        end
        nop_cycle();
        check("stall_sat", 32'(obs_stall_cnt), 32'(CNT_MAX));

        // Randomized run, including random resets.
        for (int k = 0; k < 800; k++) begin
            step(($urandom_range(0, 49) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
